// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write forwarding, busy scoreboard and post-reset clear
module regfile_mp #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_addr,
  output logic              ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr;
  logic [DW-1:0]     regs [DEPTH];
  logic [DEPTH-1:0]  busy, busy_d;
  logic              run;
  logic              w0_ok, w1_ok;
  logic [AW-1:0]     ra;
  logic              hit0, hit1;

  assign run   = (state_q == RUN) && !rst;
  assign w0_ok = we0 && !(ZERO_R0 && waddr0 == '0);
  assign w1_ok = we1 && !(ZERO_R0 && waddr1 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_ptr <= '0;
      busy    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (state_q == RUN) busy <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      CLEAR: if (clr_ptr == AW'(DEPTH - 1)) state_d = RUN;
      RUN:   ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else begin
        if (w0_ok) regs[waddr0] <= wdata0;
        if (w1_ok) regs[waddr1] <= wdata1;
      end
    end
  end

  always_comb begin
    busy_d = busy;
    for (int a = 0; a < DEPTH; a++) begin
      if ((we0 && waddr0 == AW'(a)) || (we1 && waddr1 == AW'(a))) busy_d[a] = 1'b0;
      if (busy_set && busy_addr == AW'(a)) busy_d[a] = 1'b1;
    end
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  // A write-back landing this cycle both forwards its data and hides the busy bit.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    hit0  = 1'b0;
    hit1  = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra   = raddr[i*AW +: AW];
      hit0 = we0 && waddr0 == ra;
      hit1 = we1 && waddr1 == ra;
      if (run && re[i] && !(ZERO_R0 && ra == '0)) begin
        if (hit1)      rdata[i*DW +: DW] = wdata1;
        else if (hit0) rdata[i*DW +: DW] = wdata0;
        else           rdata[i*DW +: DW] = regs[ra];
        rbusy[i] = busy[ra] && !hit0 && !hit1;
      end
    end
  end

endmodule
